fetch_prefetch_queue: RTL and testbench
=======================================

FETCH_PREFETCH_QUEUE -- requirements
Module: fetch_prefetch_queue

Interface
REQ-001 Parameters SHALL be: DEPTH, 4, queue entries (power of two, 2..8); RESET_PC, 16'h0000, first fetch address after reset.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high.
REQ-004 flush  input  1  redirect pulse; discard queue, refetch from flush_addr.
REQ-005 flush_addr  input  16  new fetch address; bit 0 ignored and treated as 0.
REQ-006 inst_valid  output  1  head entry is valid.
REQ-007 inst_data  output  16  instruction word at head.
REQ-008 inst_addr  output  16  byte address of head word.
REQ-009 inst_ready  input  1  consumer pops the head when inst_valid & inst_ready.
REQ-010 mem_req  output  1  registered level request to the memory controller fetch port.
REQ-011 mem_addr  output  16  registered fetch address; stable while mem_req is high.
REQ-012 mem_done  input  1  completion; mem_rdata is valid in any cycle mem_done is high and mem_req is high.
REQ-013 mem_rdata  input  16  fetched word.

Function
REQ-014 State machine SHALL have three states: IDLE (no request outstanding), WAIT (request outstanding, result kept), DRAIN (request outstanding, result discarded).
REQ-015 IDLE -> WAIT SHALL occur when flush=0 and count<DEPTH; mem_req<=1 and mem_addr<=fetch_pc on that edge.
REQ-016 mem_req SHALL be low in IDLE, so the controller always sees at least one cycle with mem_req low after each mem_done.
REQ-017 In WAIT, when mem_done=1 and flush=0: push {fetch_pc_issued, mem_rdata} at tail, fetch_pc<=fetch_pc+2, mem_req<=0, state<=IDLE.
REQ-018 fetch_pc SHALL increment by 2 modulo 2^16 (16'hFFFE -> 16'h0000).
REQ-019 Queue space SHALL be reserved at issue (count<DEPTH checked in IDLE), so a push never overflows.
REQ-020 inst_valid SHALL equal (count!=0); inst_data/inst_addr SHALL be driven from head storage and be don't-care when inst_valid=0.
REQ-021 Pop and push in the same cycle SHALL leave count unchanged; head and tail pointers SHALL wrap modulo DEPTH.
REQ-022 inst_ready while inst_valid=0 SHALL have no effect.
REQ-023 flush SHALL have priority over push, pop and issue: count<=0, fetch_pc<=flush_addr&16'hFFFE, and inst_valid=0 from the next cycle.
REQ-024 flush in IDLE: no request issued that cycle; state stays IDLE; issue at new pc resumes on the following cycle.
REQ-025 flush in WAIT with mem_done=0: state<=DRAIN; mem_req and mem_addr held.
REQ-026 flush in WAIT with mem_done=1: returned data discarded, mem_req<=0, state<=IDLE.
REQ-027 In DRAIN, mem_done=1: data discarded, mem_req<=0, state<=IDLE; fetch_pc not incremented.
REQ-028 flush in DRAIN SHALL update fetch_pc again and remain in DRAIN (or go to IDLE if mem_done=1 that cycle).
REQ-029 Sustained throughput with an always-ready consumer and 2-cycle controller SHALL be one word per request cycle plus one idle cycle.

Reset
REQ-030 On reset: state=IDLE, count=0, head=tail=0, fetch_pc=RESET_PC, mem_req=0, mem_addr=16'h0000, inst_valid=0.
REQ-031 Reset SHALL take effect mid-transaction; an outstanding mem_done arriving after reset deasserts SHALL be ignored while in IDLE.
REQ-032 The first request after reset SHALL be issued in the first cycle with reset low.

Verification
REQ-033 Reset release, inst_ready=0, memory returns addr as data -> requests at 0000,0002,0004,0006; after 4 pushes mem_req stays 0, inst_valid=1, inst_addr=0000, inst_data=0000.
REQ-034 Full queue, inst_ready pulsed once -> head advances to 0002; exactly one new request at 0008 issued on the next cycle.
REQ-035 flush with flush_addr=16'h1235 while WAIT on 0004 -> DRAIN, mem_addr held at 0004 until mem_done; that word never appears; next request at 1234; inst_valid low from cycle after flush until 1234 pushed.
REQ-036 fetch_pc=FFFE -> words at FFFE then 0000, inst_addr wraps correctly.
REQ-037 Simultaneous push and pop with count=2 -> count stays 2, order preserved.
REQ-038 reset asserted in WAIT, mem_done arriving one cycle after reset release -> ignored; first request at RESET_PC, no spurious push.

Source files
------------

// File: rtl/fetch_prefetch_queue_if.sv
// Fetch-side bus bundle: redirect input, instruction output stream and the
// memory controller fetch port.
interface fetch_prefetch_queue_if;
    logic        flush;
    logic [15:0] flush_addr;
    logic        inst_valid;
    logic [15:0] inst_data;
    logic [15:0] inst_addr;
    logic        inst_ready;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_done;
    logic [15:0] mem_rdata;

    // slave: the prefetch queue itself
    modport slave (
        input  flush, flush_addr, inst_ready, mem_done, mem_rdata,
        output inst_valid, inst_data, inst_addr, mem_req, mem_addr
    );

    // master: the surrounding core / memory controller
    modport master (
        output flush, flush_addr, inst_ready, mem_done, mem_rdata,
        input  inst_valid, inst_data, inst_addr, mem_req, mem_addr
    );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: issues one 16-bit fetch at a time, buffers
// returned words with their addresses and serves them to the decoder in order.
module fetch_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input logic                    clk,
    input logic                    reset,
    fetch_prefetch_queue_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [15:0]        fetch_pc_q, fetch_pc_d;
    logic               mem_req_q, mem_req_d;
    logic [15:0]        mem_addr_q, mem_addr_d;
    logic               push_en, pop_en;

    logic [15:0]        data_mem_q [DEPTH];
    logic [15:0]        addr_mem_q [DEPTH];

    assign bus.inst_valid = (count_q != '0);
    assign bus.inst_data  = data_mem_q[head_q];
    assign bus.inst_addr  = addr_mem_q[head_q];
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_addr   = mem_addr_q;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        head_d     = head_q;
        tail_d     = tail_q;
        fetch_pc_d = fetch_pc_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        push_en    = 1'b0;
        pop_en     = !bus.flush && (count_q != '0) && bus.inst_ready;

        // Space is reserved at issue, so a completing fetch can always push.
        case (state_q)
            IDLE: begin
                if (!bus.flush && (count_q < DEPTH_C)) begin
                    state_d    = WAIT;
                    mem_req_d  = 1'b1;
                    mem_addr_d = fetch_pc_q;
                end
            end
            WAIT: begin
                if (bus.mem_done) begin
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                    if (!bus.flush) begin
                        push_en    = 1'b1;
                        fetch_pc_d = fetch_pc_q + 16'd2;
                    end
                end else if (bus.flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.mem_done) begin
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (push_en) tail_d = tail_q + 1'b1;
        if (pop_en)  head_d = head_q + 1'b1;
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A redirect empties the queue and wins over push, pop and issue.
        if (bus.flush) begin
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
            fetch_pc_d = bus.flush_addr & 16'hFFFE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            fetch_pc_q <= RESET_PC;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 16'h0000;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            fetch_pc_q <= fetch_pc_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    // Payload storage carries no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push_en) begin
            data_mem_q[tail_q] <= bus.mem_rdata;
            addr_mem_q[tail_q] <= mem_addr_q;
        end
    end
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue: fill, pop/refill, flush/drain,
// address wrap, concurrent push/pop and mid-transaction reset.
module tb_fetch_prefetch_queue;
    logic clk;
    logic reset;
    int   checks;
    int   errors;
    bit   auto_resp;

    fetch_prefetch_queue_if bus();

    fetch_prefetch_queue #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock; afterwards an optional 1-cycle responder returns addr as data.
    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_resp) begin
            if (bus.mem_req && !bus.mem_done) begin
                bus.mem_done  = 1'b1;
                bus.mem_rdata = bus.mem_addr;
            end else begin
                bus.mem_done  = 1'b0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        auto_resp = 1'b0;
        reset = 1'b1;
        bus.flush = 1'b0;
        bus.flush_addr = 16'h0000;
        bus.inst_ready = 1'b0;
        bus.mem_done = 1'b0;
        bus.mem_rdata = 16'h0000;

        tick();
        tick();
        chk("rst_mem_req", 16'(bus.mem_req), 16'h0);
        chk("rst_mem_addr", bus.mem_addr, 16'h0000);
        chk("rst_inst_valid", 16'(bus.inst_valid), 16'h0);

        // Fill: requests at 0,2,4,6, one idle cycle between words
        auto_resp = 1'b1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("fill_req_hi", 16'(bus.mem_req), 16'h1);
            chk("fill_addr", bus.mem_addr, 16'(2 * i));
            tick();
            chk("fill_req_lo", 16'(bus.mem_req), 16'h0);
        end
        tick();
        chk("full_no_req", 16'(bus.mem_req), 16'h0);
        tick();
        chk("full_no_req2", 16'(bus.mem_req), 16'h0);
        chk("full_valid", 16'(bus.inst_valid), 16'h1);
        chk("full_head_addr", bus.inst_addr, 16'h0000);
        chk("full_head_data", bus.inst_data, 16'h0000);

        // Single pop on a full queue frees exactly one slot
        bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready = 1'b0;
        chk("pop_head_addr", bus.inst_addr, 16'h0002);
        chk("pop_head_data", bus.inst_data, 16'h0002);
        chk("pop_no_req_yet", 16'(bus.mem_req), 16'h0);
        tick();
        chk("refill_req", 16'(bus.mem_req), 16'h1);
        chk("refill_addr", bus.mem_addr, 16'h0008);
        tick();
        tick();
        chk("refill_once_a", 16'(bus.mem_req), 16'h0);
        tick();
        chk("refill_once_b", 16'(bus.mem_req), 16'h0);
        auto_resp = 1'b0;

        // Flush in IDLE: nothing issued that cycle, issue resumes next
        bus.flush = 1'b1;
        bus.flush_addr = 16'h0004;
        tick();
        bus.flush = 1'b0;
        chk("fidle_valid", 16'(bus.inst_valid), 16'h0);
        chk("fidle_no_req", 16'(bus.mem_req), 16'h0);
        tick();
        chk("fidle_resume_req", 16'(bus.mem_req), 16'h1);
        chk("fidle_resume_addr", bus.mem_addr, 16'h0004);

        // Flush while waiting on 0004 -> drain, request held
        bus.flush = 1'b1;
        bus.flush_addr = 16'h1235;
        tick();
        bus.flush = 1'b0;
        chk("drain_req", 16'(bus.mem_req), 16'h1);
        chk("drain_addr", bus.mem_addr, 16'h0004);
        chk("drain_valid", 16'(bus.inst_valid), 16'h0);
        tick();
        chk("drain_addr_held", bus.mem_addr, 16'h0004);
        bus.mem_done = 1'b1;
        bus.mem_rdata = 16'hBEEF;
        tick();
        bus.mem_done = 1'b0;
        chk("drain_done_req", 16'(bus.mem_req), 16'h0);
        chk("drain_discard", 16'(bus.inst_valid), 16'h0);
        tick();
        chk("redir_addr", bus.mem_addr, 16'h1234);
        chk("redir_valid_lo", 16'(bus.inst_valid), 16'h0);
        bus.mem_done = 1'b1;
        bus.mem_rdata = 16'hABCD;
        tick();
        bus.mem_done = 1'b0;
        chk("redir_valid", 16'(bus.inst_valid), 16'h1);
        chk("redir_head_addr", bus.inst_addr, 16'h1234);
        chk("redir_head_data", bus.inst_data, 16'hABCD);

        // Flush coinciding with completion: data dropped, pc -> FFFE
        tick();
        chk("wait_1236", bus.mem_addr, 16'h1236);
        bus.flush = 1'b1;
        bus.flush_addr = 16'hFFFF;
        bus.mem_done = 1'b1;
        bus.mem_rdata = 16'h5555;
        tick();
        bus.flush = 1'b0;
        bus.mem_done = 1'b0;
        chk("fdone_req", 16'(bus.mem_req), 16'h0);
        chk("fdone_valid", 16'(bus.inst_valid), 16'h0);

        // Address wrap FFFE -> 0000
        tick();
        chk("wrap_addr0", bus.mem_addr, 16'hFFFE);
        bus.mem_done = 1'b1;
        bus.mem_rdata = 16'h1111;
        tick();
        bus.mem_done = 1'b0;
        chk("wrap_head_addr", bus.inst_addr, 16'hFFFE);
        tick();
        chk("wrap_addr1", bus.mem_addr, 16'h0000);
        bus.mem_done = 1'b1;
        bus.mem_rdata = 16'h2222;
        tick();
        bus.mem_done = 1'b0;

        // Concurrent push and pop with two entries queued
        tick();
        chk("pp_req_addr", bus.mem_addr, 16'h0002);
        bus.mem_done = 1'b1;
        bus.mem_rdata = 16'h3333;
        bus.inst_ready = 1'b1;
        tick();
        bus.mem_done = 1'b0;
        bus.inst_ready = 1'b0;
        chk("pp_head_addr", bus.inst_addr, 16'h0000);
        chk("pp_head_data", bus.inst_data, 16'h2222);
        tick();
        chk("pp_next_req", bus.mem_addr, 16'h0004);
        bus.inst_ready = 1'b1;
        tick();
        chk("pp_pop2_addr", bus.inst_addr, 16'h0002);
        chk("pp_pop2_data", bus.inst_data, 16'h3333);
        tick();
        chk("pp_empty", 16'(bus.inst_valid), 16'h0);
        tick();
        chk("empty_pop_noeff", 16'(bus.inst_valid), 16'h0);
        bus.inst_ready = 1'b0;
        bus.mem_done = 1'b1;
        bus.mem_rdata = 16'h4444;
        tick();
        bus.mem_done = 1'b0;
        chk("after_empty_valid", 16'(bus.inst_valid), 16'h1);
        chk("after_empty_addr", bus.inst_addr, 16'h0004);
        chk("after_empty_data", bus.inst_data, 16'h4444);

        // Reset mid-transaction; stale mem_done after release is ignored
        tick();
        chk("pre_rst_addr", bus.mem_addr, 16'h0006);
        reset = 1'b1;
        tick();
        chk("mid_rst_req", 16'(bus.mem_req), 16'h0);
        chk("mid_rst_addr", bus.mem_addr, 16'h0000);
        chk("mid_rst_valid", 16'(bus.inst_valid), 16'h0);
        reset = 1'b0;
        bus.mem_done = 1'b1;
        bus.mem_rdata = 16'h9999;
        tick();
        bus.mem_done = 1'b0;
        chk("post_rst_req", 16'(bus.mem_req), 16'h1);
        chk("post_rst_addr", bus.mem_addr, 16'h0000);
        chk("post_rst_no_push", 16'(bus.inst_valid), 16'h0);
        tick();
        chk("post_rst_still_empty", 16'(bus.inst_valid), 16'h0);
        bus.mem_done = 1'b1;
        bus.mem_rdata = 16'h7777;
        tick();
        bus.mem_done = 1'b0;
        chk("post_rst_head_addr", bus.inst_addr, 16'h0000);
        chk("post_rst_head_data", bus.inst_data, 16'h7777);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
